// File: rtl/ft245_sync_bridge.sv
// FPGA-side responder for the FT232H synchronous 245 FIFO bus.
// Buffers host->core (TX) and core->host (RX) bytes and arbitrates FT read/write bursts.
module ft245_sync_bridge #(
  parameter int unsigned TX_AW     = 4,
  parameter int unsigned RX_AW     = 4,
  parameter int unsigned MAX_BURST = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ft_data_i,
  output logic [7:0] ft_data_o,
  output logic       ft_data_oe,
  input  logic       ft_rxf_n,
  input  logic       ft_txe_n,
  output logic       ft_rd_n,
  output logic       ft_wr_n,
  output logic       ft_oe_n,
  output logic       tx_fifo_rdy,
  input  logic       tx_fifo_rd,
  output logic [7:0] tx_data,
  output logic       rx_fifo_rdy,
  input  logic       rx_fifo_wr,
  input  logic [7:0] rx_data,
  output logic       err_o
);

  localparam int unsigned TxDepth = 1 << TX_AW;
  localparam int unsigned RxDepth = 1 << RX_AW;
  localparam logic [TX_AW:0] TxFull      = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RxFull      = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] RdStartFree = (TX_AW+1)'(3);
  localparam logic [TX_AW:0] RdStopFree  = (TX_AW+1)'(2);
  localparam logic [7:0]     BurstMax    = 8'(MAX_BURST);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRdOe  = 3'd1;
  localparam logic [2:0] StRd    = 3'd2;
  localparam logic [2:0] StRdEnd = 3'd3;
  localparam logic [2:0] StWr    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             prio_wr_q, prio_wr_d;
  logic [7:0]       burst_q, burst_d;
  logic             txe_hi_q, txe_hi_d;
  logic             err_q, err_d;
  logic             tx_rdy_q, rx_rdy_q;
  logic [7:0]       tx_data_q;

  logic [7:0]       tx_mem [TxDepth];
  logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]       rx_mem [RxDepth];
  logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;

  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             rd_ok, wr_ok;
  logic [TX_AW:0]   tx_free_q, tx_free_d;

  // RD_END still captures a byte presented with RXF# low: the free>=2 margin covers it.
  assign tx_push = ((state_q == StRd) || (state_q == StRdEnd)) && !ft_rxf_n;
  assign tx_pop  = tx_fifo_rd && tx_rdy_q;
  assign rx_push = rx_fifo_wr && rx_rdy_q;
  assign rx_pop  = (state_q == StWr) && !ft_txe_n && !ft_wr_n;

  assign tx_cnt_d  = tx_cnt_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
  assign rx_cnt_d  = rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
  assign tx_free_q = TxFull - tx_cnt_q;
  assign tx_free_d = TxFull - tx_cnt_d;

  assign rd_ok = !ft_rxf_n && (tx_free_q >= RdStartFree);
  assign wr_ok = !ft_txe_n && (rx_cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    burst_d   = burst_q;
    txe_hi_d  = 1'b0;
    case (state_q)
      StIdle: begin
        burst_d = 8'd0;
        if (rd_ok && (!wr_ok || !prio_wr_q)) begin
          state_d = StRdOe;
        end else if (wr_ok) begin
          state_d = StWr;
        end
      end
      StRdOe: state_d = StRd;
      StRd: begin
        burst_d = burst_q + 8'(tx_push);
        if (ft_rxf_n || (tx_free_d <= RdStopFree) || (burst_d == BurstMax)) begin
          state_d = StRdEnd;
        end
      end
      StRdEnd: begin
        state_d   = StIdle;
        prio_wr_d = 1'b1;
      end
      StWr: begin
        burst_d  = burst_q + 8'(rx_pop);
        txe_hi_d = ft_txe_n;
        // Leave after two consecutive TXE# high cycles so reads are not starved.
        if ((rx_cnt_d == '0) || (ft_txe_n && txe_hi_q) || (burst_d == BurstMax)) begin
          state_d   = StIdle;
          prio_wr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d = err_q | (tx_fifo_rd & ~tx_rdy_q) | (rx_fifo_wr & ~rx_rdy_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b0;
      burst_q   <= 8'd0;
      txe_hi_q  <= 1'b0;
      err_q     <= 1'b0;
      tx_rdy_q  <= 1'b0;
      rx_rdy_q  <= 1'b1;
      tx_data_q <= 8'h00;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      burst_q   <= burst_d;
      txe_hi_q  <= txe_hi_d;
      err_q     <= err_d;
      tx_rdy_q  <= (tx_cnt_d != '0);
      rx_rdy_q  <= (rx_cnt_d != RxFull);
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      if (tx_pop) begin
        tx_data_q <= tx_mem[tx_rp_q];
        tx_rp_q   <= tx_rp_q + TX_AW'(1);
      end
      if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RX_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= ft_data_i;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

  // Strobes decode straight from the state register so reset releases the bus at once.
  assign ft_oe_n     = !((state_q == StRdOe) || (state_q == StRd) || (state_q == StRdEnd));
  assign ft_rd_n     = (state_q != StRd);
  assign ft_wr_n     = !((state_q == StWr) && (rx_cnt_q != '0));
  assign ft_data_oe  = (state_q == StWr);
  assign ft_data_o   = (state_q == StWr) ? rx_mem[rx_rp_q] : 8'h00;
  assign tx_fifo_rdy = tx_rdy_q;
  assign rx_fifo_rdy = rx_rdy_q;
  assign tx_data     = tx_data_q;
  assign err_o       = err_q;

endmodule

// File: doc/ft245_sync_bridge.md
Name: ft245_sync_bridge

Overview:
- FPGA-side responder for the FT232H synchronous 245 FIFO bus. It is the other end of the byte-FIFO handshake that max5863_if initiates.
- Host→FPGA bytes are pulled from the FTDI chip into a TX buffer, then served to max5863_if via tx_fifo_rdy/tx_fifo_rd/tx_data.
- Bytes pushed by max5863_if via rx_fifo_rdy/rx_fifo_wr/rx_data are buffered, then written to the FTDI chip for the host.
- Sits between top-level FTDI pins and max5863_if; clocked by FTDI CLKOUT (60 MHz).

Parameters:
- TX_AW, 4: log2 TX buffer depth (16 bytes).
- RX_AW, 4: log2 RX buffer depth (16 bytes).
- MAX_BURST, 32: maximum bytes per FT read or write burst before re-arbitration (1..255).

Ports:
- clk  in  1  FTDI CLKOUT; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ft_data_i  in  8  FTDI data bus, input path.
- ft_data_o  out  8  FTDI data bus, output path.
- ft_data_oe  out  1  1 = FPGA drives the data bus.
- ft_rxf_n  in  1  0 = FTDI holds host data.
- ft_txe_n  in  1  0 = FTDI can accept data.
- ft_rd_n  out  1  FTDI read strobe.
- ft_wr_n  out  1  FTDI write strobe.
- ft_oe_n  out  1  FTDI output enable.
- tx_fifo_rdy  out  1  TX buffer non-empty.
- tx_fifo_rd  in  1  core pops one TX byte.
- tx_data  out  8  popped TX byte.
- rx_fifo_rdy  out  1  RX buffer has a free slot.
- rx_fifo_wr  in  1  core pushes rx_data.
- rx_data  in  8  byte from core.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release): both buffers empty; FSM=IDLE; ft_rd_n=ft_wr_n=ft_oe_n=1; ft_data_oe=0; ft_data_o=0; tx_data=0; tx_fifo_rdy=0; rx_fifo_rdy=1; err_o=0; priority=READ.
- Core TX side:
  - Pop occurs on an edge where tx_fifo_rd=1 and tx_fifo_rdy=1.
  - tx_data is registered and shows the popped byte from the next cycle; it holds otherwise.
  - tx_fifo_rd while empty: no pop, tx_data holds, err_o set.
- Core RX side:
  - Push occurs on an edge where rx_fifo_wr=1 and rx_fifo_rdy=1; rx_data is captured on that edge.
  - rx_fifo_wr while full: byte dropped, err_o set.
- err_o is cleared only by reset.
- FSM states: IDLE, RD_OE, RD, RD_END, WR.
- IDLE:
  - rd_ok = !ft_rxf_n && tx_free>=3.
  - wr_ok = !ft_txe_n && rx_count>=1.
  - Both ok: take the side named by priority. Otherwise take whichever is ok.
  - Next state is RD_OE (read) or WR (write).
- RD_OE: ft_oe_n=0, ft_rd_n=1 for exactly 1 cycle, then RD.
- RD:
  - ft_oe_n=0, ft_rd_n=0.
  - Each edge with !ft_rxf_n && !ft_rd_n writes ft_data_i into the TX buffer and increments the burst count.
  - Exit to RD_END when any of: ft_rxf_n=1, tx_free<=2 after this edge's pushes, or burst count reaches MAX_BURST.
- RD_END:
  - ft_rd_n=1, ft_oe_n=1 for 1 cycle.
  - A byte presented this cycle with ft_rxf_n=0 is still captured (skid; guaranteed by the free>=2 margin).
  - Then IDLE with priority=WRITE.
- WR:
  - ft_data_oe=1; ft_data_o = RX buffer head (show-ahead).
  - ft_wr_n=0 while rx_count>=1.
  - Pop and increment burst count only on an edge with !ft_txe_n && !ft_wr_n. If ft_txe_n=1, the same byte is held and re-presented.
  - Exit to IDLE when any of: RX buffer empty, ft_txe_n=1 for 2 consecutive cycles, or burst reaches MAX_BURST. On exit, ft_data_oe is dropped and priority=READ.
- Bus turnaround: ft_data_oe=1 only in WR. ft_oe_n=0 only in RD_OE/RD/RD_END. At least one IDLE cycle separates RD_END from WR.
- Simultaneous core push/pop with FTDI transfers on the same buffer in the same cycle: counts update by net (+1−1); no loss.
- Buffer pointers wrap modulo depth.
- Full = count==depth; empty = count==0.
- tx_fifo_rdy = (tx_count!=0); rx_fifo_rdy = (rx_count!=depth). Both are registered.
- Reset mid-burst: strobes deassert immediately (async); buffered data is discarded.

Test Plan:
- Host preload 0x00..0x09, core pulls continuously → RD_OE one cycle before first ft_rd_n=0; tx_data sequence 00..09 in order; err_o=0.
- Host preload 20 bytes, core not reading → ft_rd_n rises with tx_count=14; RD_END captures one skid byte (15); no byte lost once core drains; all 20 received in order.
- Core pushes 0xA0..0xA7 with ft_txe_n=0 → ft_wr_n low 8 cycles; ft_data_o=A0..A7; ft_data_oe drops after last byte.
- As above, but ft_txe_n=1 for cycle 3 only → A2 held 2 cycles; host still sees A0..A7 with no duplicate.
- rxf and txe both asserted continuously, MAX_BURST=4 → bursts alternate RD(4)/WR(4); at least one IDLE between RD_END and WR; ft_data_oe and ft_oe_n=0 never both active.
- tx_fifo_rd with empty buffer; 17 rx_fifo_wr pushes with txe_n=1 → err_o=1 and stays 1; 17th byte dropped; rst_n=0 mid-burst → strobes high immediately; err_o=0; tx_fifo_rdy=0.
